// File: rtl/sr_iter.sv
// ---------------------------------------------------------------------------
// sr_iter -- multicycle right shifter (srl / sra), one bit per clock.
//
// The controller pulses START while the block is not busy. The operand, the
// shift amount and the mode are captured on that edge. The shifter then moves
// one bit per cycle until the count reaches zero. The result is transferred to
// Y, and DONE pulses for exactly one cycle. A START seen in the DONE cycle is
// accepted as a back-to-back launch. A START seen while BUSY is ignored.
//
// Ports:
//   CLK    in   1    rising-edge clock
//   RST_N  in   1    asynchronous active-low reset
//   START  in   1    launch request, honoured only when BUSY is low
//   A      in   n    operand, captured on an accepted START
//   SHAMT  in   SW   shift amount 0..n-1, captured on an accepted START
//   ARITH  in   1    1 = sign fill, 0 = zero fill, captured on an accepted START
//   ROT    in   1    (SR_ITER_ROTATE_EN only) 1 = rotate right, overrides ARITH
//   Y      out  n    result register, updated only on the DONE transfer
//   BUSY   out  1    high while shifting
//   DONE   out  1    one-cycle pulse: Y is valid
//
// Optional feature macro: SR_ITER_ROTATE_EN adds the ROT port and rotate mode.
// ---------------------------------------------------------------------------
module sr_iter #(
    parameter  int n  = 32,
    localparam int SW = $clog2(n)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [n-1:0]  A,
    input  logic [SW-1:0] SHAMT,
    input  logic          ARITH,
`ifdef SR_ITER_ROTATE_EN
    input  logic          ROT,
`endif
    output logic [n-1:0]  Y,
    output logic          BUSY,
    output logic          DONE
);

    // The encoding makes bit 0 equal to BUSY and bit 1 equal to DONE. The
    // status outputs are therefore taken directly from the state register.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] FIN   = 2'b10;

    logic [1:0]    r_state;
    logic [n-1:0]  r_sr;
    logic [SW-1:0] r_cnt;
    logic          r_arith;
    logic          r_rot;
    logic [n-1:0]  r_y;

    logic [1:0]    w_state_nxt;
    logic [n-1:0]  w_sr_nxt;
    logic [SW-1:0] w_cnt_nxt;
    logic          w_arith_nxt;
    logic          w_rot_nxt;
    logic [n-1:0]  w_y_nxt;
    logic          w_rot_in;

    // Selects the bit that enters at the MSB on each step.
    // Rotate takes priority over arithmetic fill.
    function automatic logic fill_bit(input logic [n-1:0] sr,
                                      input logic         arith,
                                      input logic         rot);
        logic f;
        if (rot) begin
            f = sr[0];
        end else if (arith) begin
            f = sr[n-1];
        end else begin
            f = 1'b0;
        end
        return f;
    endfunction

`ifdef SR_ITER_ROTATE_EN
    assign w_rot_in = ROT;
`else
    assign w_rot_in = 1'b0;
`endif

    // Next-state and datapath update for the IDLE / SHIFT / FIN sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_arith_nxt = r_arith;
        w_rot_nxt   = r_rot;
        w_y_nxt     = r_y;
        case (r_state)
            IDLE, FIN: begin
                // A launch is accepted from IDLE and also from FIN. Accepting
                // from FIN supports back-to-back operation.
                if (START) begin
                    w_sr_nxt    = A;
                    w_cnt_nxt   = SHAMT;
                    w_arith_nxt = ARITH;
                    w_rot_nxt   = w_rot_in;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt != {SW{1'b0}}) begin
                    w_sr_nxt  = {fill_bit(r_sr, r_arith, r_rot), r_sr[n-1:1]};
                    w_cnt_nxt = r_cnt - {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    w_y_nxt     = r_sr;
                    w_state_nxt = FIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, operand and result registers. Reset clears all of them at once,
    // which aborts any shift in flight without a DONE pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_sr    <= {n{1'b0}};
            r_cnt   <= {SW{1'b0}};
            r_arith <= 1'b0;
            r_rot   <= 1'b0;
            r_y     <= {n{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_arith <= w_arith_nxt;
            r_rot   <= w_rot_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign Y    = r_y;
    assign BUSY = r_state[0];
    assign DONE = r_state[1];

endmodule

// File: tb/tb_sr_iter.sv
// ---------------------------------------------------------------------------
// Testbench for sr_iter: scoreboard of expected results pushed when a START is
// accepted. A monitor pops one entry on every DONE and compares Y, the latency
// and the BUSY duration.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sr_iter;

    localparam int N = 32;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [31:0] A = 32'd0;
    logic [4:0]  SHAMT = 5'd0;
    logic        ARITH = 1'b0;
    logic        rot = 1'b0;
    logic [31:0] Y;
    logic        BUSY;
    logic        DONE;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_run = 0;
    int dones = 0;

    typedef struct {
        logic [31:0] y;
        int          k;
        int          shamt;
    } exp_t;
    exp_t q[$];

    sr_iter #(.n(N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .SHAMT (SHAMT),
        .ARITH (ARITH),
`ifdef SR_ITER_ROTATE_EN
        .ROT   (rot),
`endif
        .Y     (Y),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: the shift result defined directly in terms of the operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s,
                                              input logic ar, input logic rt);
        logic [31:0] r;
        if (rt)      r = (a >> s) | (a << (32 - s));
        else if (ar) r = $unsigned($signed(a) >>> s);
        else         r = a >> s;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor and scoreboard. The monitor pops and checks on DONE. A new entry
    // is pushed when the upcoming edge will accept START.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (BUSY) busy_run++;
            if (DONE) begin
                exp_t e;
                dones++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got DONE with Y=%h, expected no pulse", Y);
                end else begin
                    e = q.pop_front();
                    check("result_y", Y, e.y);
                    check("latency", 32'(cyc - e.k), 32'(e.shamt + 1));
                    check("busy_cycles", 32'(busy_run), 32'(e.shamt + 1));
                end
                busy_run = 0;
            end
            if (START && !BUSY) begin
                exp_t n_e;
`ifdef SR_ITER_ROTATE_EN
                n_e.y = ref_shift(A, int'(SHAMT), ARITH, rot);
`else
                n_e.y = ref_shift(A, int'(SHAMT), ARITH, 1'b0);
`endif
                n_e.k = cyc + 1;
                n_e.shamt = int'(SHAMT);
                q.push_back(n_e);
            end
        end
    end

    // Reset discards everything in flight.
    always @(negedge RST_N) begin
        q.delete();
        busy_run = 0;
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE in 100 cycles, expected DONE");
        end
    endtask

    // Single-cycle START. After the launch edge the operands become random
    // garbage, because they are don't-care outside the accepting edge.
    task automatic launch(input logic [31:0] a, input int s, input logic ar,
                          input logic rt);
        @(posedge CLK); #1;
        A = a; SHAMT = 5'(s); ARITH = ar; rot = rt; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = $urandom; SHAMT = 5'($urandom); ARITH = 1'($urandom);
        rot = 1'($urandom);
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_y", Y, 32'h0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK); RST_N = 1'b1;

        // Directed cases. Each result is checked by the monitor.
        launch(32'h8000_0000, 4, 1'b0, 1'b0); wait_done();
        launch(32'h8000_0000, 4, 1'b1, 1'b0); wait_done();
        launch(32'h7FFF_FFF0, 4, 1'b1, 1'b0); wait_done();
        launch(32'h1234_5678, 0, 1'b0, 1'b0); wait_done();
        launch(32'h8000_0000, 31, 1'b1, 1'b0); wait_done();
`ifdef SR_ITER_ROTATE_EN
        launch(32'h0000_0001, 1, 1'b1, 1'b1); wait_done();
        launch(32'h0000_ABCD, 8, 1'b0, 1'b1); wait_done();
`endif

        // START held high across the whole first operation, with the operands
        // changed while BUSY.
        @(posedge CLK); #1;
        A = 32'h0000_00F0; SHAMT = 5'd4; ARITH = 1'b0; START = 1'b1;
        repeat (2) @(posedge CLK);
        #1 A = 32'hAAAA_AAAA; SHAMT = 5'd8; ARITH = 1'b1;
        wait_done();
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_busy", {31'd0, BUSY}, 32'd1);
        wait_done();

        // Asynchronous reset in the middle of a shift.
        launch(32'hFFFF_FFFF, 20, 1'b0, 1'b0);
        repeat (4) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("abort_y", Y, 32'h0);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        repeat (30) @(posedge CLK);
        check("abort_no_done_q", 32'(q.size()), 32'd0);

        // Random stream. START is issued freely, including while BUSY and in
        // the FIN cycle.
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK); #1;
            START = ($urandom_range(0, 3) == 0);
            A = $urandom; SHAMT = 5'($urandom); ARITH = 1'($urandom);
            rot = 1'($urandom);
        end
        START = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            if (q.size() == 0) break;
        end
        #1;
        check("drain_q_empty", 32'(q.size()), 32'd0);
        check("some_dones", {31'd0, (dones > 20)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_iter.md
Name: sr_iter

Overview:
- Multicycle right shifter: the right-direction counterpart to the existing combinational left shifter (sl2).
- Supports logical (srl) and arithmetic (sra) right shifts by a variable amount, one bit per clock.
- Sits beside the ALU in the multicycle datapath. The controller launches it with START and waits for DONE.
- Replaces a wide combinational barrel shifter to save area.

Parameters:
n, 32, data width in bits (power of two, >= 4)
SW, $clog2(n), width of shift amount (derived; not overridden)

Ports:
CLK  input  1  clock, rising-edge
RST_N  input  1  asynchronous active-low reset
START  input  1  launch request; sampled only when not BUSY
A  input  n  operand; captured on accepted START
SHAMT  input  SW  shift amount 0..n-1; captured on accepted START
ARITH  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on accepted START
Y  output  n  result register
BUSY  output  1  high while shifting
DONE  output  1  one-cycle pulse: Y valid

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RST_N).
- While RST_N=0: state IDLE, Y=0, BUSY=0, DONE=0, internal shift register=0, counter=0. Reset takes effect immediately, independent of CLK.
- Reset mid-operation aborts the shift and produces no DONE.
- States:
  - IDLE: BUSY=0, DONE=0.
  - SHIFT: BUSY=1, DONE=0.
  - FIN: BUSY=0, DONE=1.
- IDLE:
  - START=1 at edge k: capture A, SHAMT and ARITH into the shift register, counter and mode bit; go to SHIFT.
  - START=0: stay in IDLE.
- SHIFT, counter != 0: shift register >>= 1; fill MSB with the old MSB if ARITH, else 0; counter -= 1.
- SHIFT, counter == 0: Y <= shift register; go to FIN.
- Latency: DONE is asserted after edge k+SHAMT+1 (SHAMT+1 cycles); SHAMT=0 gives 1 cycle.
- FIN, DONE high for exactly one cycle:
  - START=0: return to IDLE.
  - START=1: accepted as a new launch (back-to-back), go to SHIFT. DONE falls next cycle as normal.
- START while BUSY=1: ignored. The operands in flight are not disturbed.
- A, SHAMT and ARITH are don't-care except on the accepted-START edge.
- Y holds its value until the next FIN transfer or reset. Y is never updated in mid-shift.
- No width growth: all arithmetic on n bits. The counter is SW bits and never wraps, because it stops at 0.

Optional Feature:
- Macro: SR_ITER_ROTATE_EN.
- Defined:
  - Adds input port ROT (1 bit), captured with the other operands on an accepted START.
  - ROT=1 performs rotate-right: the MSB is filled with the old LSB. ROT overrides ARITH.
  - Latency is unchanged.
- Undefined:
  - ROT port and rotate logic are absent.
  - Behaviour is exactly as specified above.

Test Plan:
1. RST_N=0 asserted asynchronously in mid-shift (A=0xFFFFFFFF, SHAMT=20, 5 cycles in) -> Y=0, BUSY=0, DONE=0 immediately, before the next CLK edge. No DONE pulse after RST_N=1 with START=0.
2. A=0x80000000, SHAMT=4, ARITH=0, START one cycle -> BUSY high 5 cycles, DONE pulse after edge k+5, Y=0x08000000.
3. Same with ARITH=1 -> Y=0xF8000000. Then A=0x7FFFFFF0, SHAMT=4, ARITH=1 -> Y=0x07FFFFFF.
4. SHAMT=0, A=0x12345678 -> DONE one cycle after START, Y=0x12345678. SHAMT=31, A=0x80000000, ARITH=1 -> DONE after 32 cycles, Y=0xFFFFFFFF.
5. START held high throughout, first op A=0x000000F0, SHAMT=4, ARITH=0; A changed to 0xAAAAAAAA while BUSY:
   - first result Y=0x0000000F, unaffected by the change;
   - START in the FIN cycle launches the second op, with BUSY high on the next cycle;
   - no DONE pulses are lost or doubled.
6. With SR_ITER_ROTATE_EN: A=0x00000001, SHAMT=1, ROT=1, ARITH=1 -> Y=0x80000000. A=0x0000ABCD, SHAMT=8, ROT=1 -> Y=0xCD0000AB.
